// File: rtl/fifo_wr_frontend.sv
// fifo_wr_frontend: valid/ready word ingress feeding the async FIFO write port through a 2-entry skid buffer, with stall-timeout packet drop and saturating statistics.
// Latency: a word accepted at edge N is written to the FIFO at edge N+1 at the earliest; one word per cycle sustained.
// Backpressure: registered s_ready falls once the skid entry fills; fifo_full gates fifo_wr_en combinationally.
// Build option: define WR_PARITY_EN to widen fifo_data by one even-parity bit above the data.
module fifo_wr_frontend #(
    parameter int WIDTH       = 8,
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             wr_clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic             drop_mode,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
`ifdef WR_PARITY_EN
    output logic [WIDTH:0]   fifo_data,
`else
    output logic [WIDTH-1:0] fifo_data,
`endif
    output logic             busy,
    output logic [CNT_W-1:0] words_written,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] pkts_written,
    output logic [CNT_W-1:0] words_dropped
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        STALL = 2'd2,
        DROP  = 2'd3
    } state_t;

    // Timer is 8 bits because the stall limit never exceeds 255.
    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    state_t           state;
    state_t           state_nxt;

    // Head entry: the word presented to the FIFO.
    logic             hd_vld;
    logic             hd_vld_nxt;
    logic [WIDTH-1:0] hd_data;
    logic [WIDTH-1:0] hd_data_nxt;
    logic             hd_last;
    logic             hd_last_nxt;

    // Skid entry: catches the word accepted while the head is blocked.
    logic             sk_vld;
    logic             sk_vld_nxt;
    logic [WIDTH-1:0] sk_data;
    logic [WIDTH-1:0] sk_data_nxt;
    logic             sk_last;
    logic             sk_last_nxt;

    logic [7:0]       timer;
    logic [7:0]       timer_nxt;
    logic [7:0]       timer_inc;

    // Set when the packet being dropped already ended inside the flushed buffer.
    logic             drop_exit;
    logic             drop_exit_nxt;

    logic             s_ready_nxt;
    logic             accept;
    logic             stall_now;
    logic             limit_hit;
    logic             go_drop;
    logic [1:0]       drop_inc;

    // Adds a small increment and clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign accept     = s_valid & s_ready;
    // The only combinational path from fifo_full: a write is blocked in the same cycle full rises.
    assign fifo_wr_en = hd_vld & ~fifo_full & (state != DROP);
    assign stall_now  = hd_vld & fifo_full & (state != DROP);
    assign timer_inc  = (timer == 8'hFF) ? timer : timer + 8'd1;
    assign limit_hit  = drop_mode & (timer_inc >= LIMIT);
    // stall_now is never true in IDLE (head empty) or DROP, so this only fires from PASS/STALL.
    assign go_drop    = stall_now & limit_hit;
    assign busy       = (state != IDLE) | hd_vld | sk_vld;

`ifdef WR_PARITY_EN
    assign fifo_data = {^hd_data, hd_data};
`else
    assign fifo_data = hd_data;
`endif

    // Skid buffer next-state: refill head from skid or input, park in skid when head is blocked.
    always_comb begin
        hd_vld_nxt  = hd_vld;
        hd_data_nxt = hd_data;
        hd_last_nxt = hd_last;
        sk_vld_nxt  = sk_vld;
        sk_data_nxt = sk_data;
        sk_last_nxt = sk_last;
        if (go_drop || (state == DROP)) begin
            // Flushed words are counted separately; the data fields are don't-care.
            hd_vld_nxt = 1'b0;
            sk_vld_nxt = 1'b0;
        end else if (sk_vld) begin
            // s_ready is low whenever the skid is occupied, so no accept here.
            if (fifo_wr_en) begin
                hd_data_nxt = sk_data;
                hd_last_nxt = sk_last;
                sk_vld_nxt  = 1'b0;
            end
        end else if (accept) begin
            if (!hd_vld || fifo_wr_en) begin
                hd_vld_nxt  = 1'b1;
                hd_data_nxt = s_data;
                hd_last_nxt = s_last;
            end else begin
                sk_vld_nxt  = 1'b1;
                sk_data_nxt = s_data;
                sk_last_nxt = s_last;
            end
        end else if (fifo_wr_en) begin
            hd_vld_nxt = 1'b0;
        end
    end

    // Drop accounting: flushed entries on entry, then every word accepted while dropping.
    always_comb begin
        drop_inc      = 2'd0;
        drop_exit_nxt = drop_exit;
        if (go_drop) begin
            drop_inc      = {1'b0, hd_vld} + {1'b0, sk_vld} + {1'b0, accept};
            drop_exit_nxt = (hd_vld & hd_last) | (sk_vld & sk_last) | (accept & s_last);
        end else if (state == DROP) begin
            drop_inc      = {1'b0, accept};
            drop_exit_nxt = 1'b0;
        end
    end

    // FSM next state, stall timer and registered-ready computation.
    always_comb begin
        state_nxt = state;
        timer_nxt = stall_now ? timer_inc : 8'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = PASS;
                end
            end
            PASS: begin
                if (go_drop) begin
                    state_nxt = DROP;
                end else if (stall_now) begin
                    state_nxt = STALL;
                end else if (!hd_vld_nxt) begin
                    state_nxt = IDLE;
                end
            end
            STALL: begin
                if (go_drop) begin
                    state_nxt = DROP;
                end else if (!fifo_full) begin
                    state_nxt = PASS;
                end
            end
            DROP: begin
                if (drop_exit || (accept && s_last)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (go_drop) begin
            timer_nxt = 8'd0;
        end
        // While dropping keep accepting, unless the packet already ended in the flushed
        // buffer: then hold off one cycle so the next packet's first word is not discarded.
        if (state_nxt == DROP) begin
            s_ready_nxt = ~drop_exit_nxt;
        end else begin
            s_ready_nxt = ~sk_vld_nxt;
        end
    end

    // Control registers.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= 8'd0;
            drop_exit <= 1'b0;
            s_ready   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            drop_exit <= drop_exit_nxt;
            s_ready   <= s_ready_nxt;
        end
    end

    // Skid buffer registers.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            hd_vld  <= 1'b0;
            hd_data <= '0;
            hd_last <= 1'b0;
            sk_vld  <= 1'b0;
            sk_data <= '0;
            sk_last <= 1'b0;
        end else begin
            hd_vld  <= hd_vld_nxt;
            hd_data <= hd_data_nxt;
            hd_last <= hd_last_nxt;
            sk_vld  <= sk_vld_nxt;
            sk_data <= sk_data_nxt;
            sk_last <= sk_last_nxt;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            words_written <= '0;
            pkts_written  <= '0;
            stall_cycles  <= '0;
            words_dropped <= '0;
        end else begin
            words_written <= sat_add(words_written, {1'b0, fifo_wr_en});
            pkts_written  <= sat_add(pkts_written, {1'b0, fifo_wr_en & hd_last});
            stall_cycles  <= sat_add(stall_cycles, {1'b0, stall_now});
            words_dropped <= sat_add(words_dropped, drop_inc);
        end
    end

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Testbench for fifo_wr_frontend: table-driven streaming vectors plus directed stall, drop, reset and saturation sequences.
// Two instances share stimulus: main (CNT_W=16) and a narrow-counter copy (CNT_W=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_fifo_wr_frontend;

    localparam int WIDTH = 8;
`ifdef WR_PARITY_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif

    logic             wr_clk = 1'b0;
    logic             reset = 1'b1;
    logic             s_valid = 1'b0;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_last = 1'b0;
    logic             drop_mode = 1'b0;
    logic             fifo_full = 1'b0;

    logic             s_ready;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_data;
    logic             busy;
    logic [15:0]      words_written;
    logic [15:0]      stall_cycles;
    logic [15:0]      pkts_written;
    logic [15:0]      words_dropped;

    logic             sat_s_ready;
    logic             sat_wr_en;
    logic [DW-1:0]    sat_fifo_data;
    logic             sat_busy;
    logic [3:0]       sat_words_written;
    logic [3:0]       sat_stall_cycles;
    logic [3:0]       sat_pkts_written;
    logic [3:0]       sat_words_dropped;

    fifo_wr_frontend #(.WIDTH(WIDTH), .STALL_LIMIT(4), .CNT_W(16)) dut (
        .wr_clk(wr_clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .drop_mode(drop_mode), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .busy(busy),
        .words_written(words_written), .stall_cycles(stall_cycles),
        .pkts_written(pkts_written), .words_dropped(words_dropped)
    );

    fifo_wr_frontend #(.WIDTH(WIDTH), .STALL_LIMIT(4), .CNT_W(4)) dut_sat (
        .wr_clk(wr_clk), .reset(reset), .s_valid(s_valid), .s_ready(sat_s_ready),
        .s_data(s_data), .s_last(s_last), .drop_mode(drop_mode), .fifo_full(fifo_full),
        .fifo_wr_en(sat_wr_en), .fifo_data(sat_fifo_data), .busy(sat_busy),
        .words_written(sat_words_written), .stall_cycles(sat_stall_cycles),
        .pkts_written(sat_pkts_written), .words_dropped(sat_words_dropped)
    );

    always #5 wr_clk = ~wr_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Observations from the most recent run_stream call.
    logic [7:0] got[$];
    int n_acc;
    int n_wr_full;
    int occ_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offers nwords words base, base+1, ... (last on the final one) for a fixed number of
    // cycles, with fifo_full high in cycles full_from..full_to; records FIFO writes in order.
    task automatic run_stream(input int nwords, input logic [7:0] base, input int full_from,
                              input int full_to, input logic dmode, input int cycles);
        int nxt = 0;
        got.delete();
        n_acc = 0;
        n_wr_full = 0;
        occ_low = -1;
        for (int c = 0; c < cycles; c++) begin
            @(posedge wr_clk);
            #1;
            fifo_full = (c >= full_from) && (c <= full_to);
            drop_mode = dmode;
            s_valid   = (nxt < nwords);
            s_data    = base + 8'(nxt);
            s_last    = (nxt == nwords - 1);
            @(negedge wr_clk);
            if (fifo_wr_en && fifo_full) n_wr_full++;
            if (!s_ready && s_valid && occ_low < 0) occ_low = n_acc - got.size();
            if (fifo_wr_en) got.push_back(fifo_data[7:0]);
            if (s_valid && s_ready) begin
                nxt++;
                n_acc++;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge wr_clk);
        #1;
        reset     = 1'b1;
        s_valid   = 1'b0;
        fifo_full = 1'b0;
        drop_mode = 1'b0;
        @(posedge wr_clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       last;
        logic       full;
        logic       exp_rdy;
        logic       exp_wr;
        logic [7:0] exp_dat;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Streaming 0x01..0x08: each word appears on fifo_data the cycle after it is offered.
        //            vld   dat    last  full  rdy   wr    dat    busy
        vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        for (int i = 1; i <= 6; i++) begin
            vecs[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b1, 1'b1, 8'(i), 1'b1};
        end
        vecs[7] = '{1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};

        // Reset state while reset is held.
        #3;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_fifo_data", fifo_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_words_written", words_written, 0);
        chk("rst_counters_or", stall_cycles | pkts_written | words_dropped, 0);
        @(posedge wr_clk);
        #1;
        reset = 1'b0;

        // Table-driven stream.
        for (int i = 0; i < 10; i++) begin
            @(posedge wr_clk);
            #1;
            s_valid   = vecs[i].vld;
            s_data    = vecs[i].dat;
            s_last    = vecs[i].last;
            fifo_full = vecs[i].full;
            @(negedge wr_clk);
            chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].exp_rdy);
            chk($sformatf("vec%0d_wr_en", i), fifo_wr_en, vecs[i].exp_wr);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            if (vecs[i].exp_wr) chk($sformatf("vec%0d_data", i), fifo_data[7:0], vecs[i].exp_dat);
        end
        chk("stream_words_written", words_written, 8);
        chk("stream_pkts_written", pkts_written, 1);
        chk("stream_stall_cycles", stall_cycles, 0);

        // Five full cycles mid-stream, no drop: skid fills, order and count preserved.
        run_stream(8, 8'h01, 3, 7, 1'b0, 24);
        chk("stall_no_write_while_full", n_wr_full, 0);
        chk("stall_occupancy_at_ready_low", occ_low, 2);
        chk("stall_words_out", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) begin
            chk($sformatf("stall_order%0d", i), got[i], 8'(i + 1));
        end
        chk("stall_stall_cycles", stall_cycles, 5);
        chk("stall_words_written", words_written, 16);
        chk("stall_pkts_written", pkts_written, 2);
        chk("stall_busy_after", busy, 0);

        // Drop: FIFO stays full, limit 4, 6-word packet is entirely discarded.
        run_stream(6, 8'h11, 0, 1000, 1'b1, 20);
        chk("drop_no_writes", got.size(), 0);
        chk("drop_all_accepted", n_acc, 6);
        chk("drop_words_dropped", words_dropped, 6);
        chk("drop_stall_cycles", stall_cycles, 9);
        chk("drop_words_written", words_written, 16);
        chk("drop_busy_after", busy, 0);
        chk("drop_ready_after", s_ready, 1);

        // Reset while the skid entry is occupied.
        run_stream(3, 8'h31, 0, 1000, 1'b0, 4);
        chk("pre_reset_ready_low", s_ready, 0);
        chk("pre_reset_busy", busy, 1);
        #2;
        reset     = 1'b1;
        fifo_full = 1'b0;
        s_valid   = 1'b0;
        #1;
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_wr_en", fifo_wr_en, 0);
        chk("midrst_fifo_data", fifo_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_counters_or", words_written | stall_cycles | pkts_written | words_dropped, 0);
        @(posedge wr_clk);
        #1;
        reset = 1'b0;
        @(negedge wr_clk);
        chk("postrst_ready_before_edge", s_ready, 0);
        @(negedge wr_clk);
        chk("postrst_ready", s_ready, 1);
        run_stream(4, 8'h21, 1, 0, 1'b0, 10);
        chk("postrst_words_out", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            chk($sformatf("postrst_order%0d", i), got[i], 8'h21 + 8'(i));
        end
        chk("postrst_words_written", words_written, 4);
        chk("postrst_pkts_written", pkts_written, 1);

        // Counter saturation on the 4-bit instance.
        do_reset();
        run_stream(20, 8'h40, 1, 0, 1'b0, 26);
        chk("sat_main_words_written", words_written, 20);
        chk("sat_words_written", sat_words_written, 15);
        run_stream(3, 8'h60, 1, 0, 1'b0, 6);
        chk("sat_words_written_hold", sat_words_written, 15);
        chk("sat_main_words_written2", words_written, 23);
        chk("sat_pkts_written", sat_pkts_written, 2);

`ifdef WR_PARITY_EN
        // Even parity bit above the data.
        @(posedge wr_clk);
        #1;
        s_valid = 1'b1;
        s_data  = 8'h07;
        s_last  = 1'b1;
        @(posedge wr_clk);
        #1;
        s_data  = 8'h03;
        @(negedge wr_clk);
        chk("parity07_wr_en", fifo_wr_en, 1);
        chk("parity07_bit", fifo_data[WIDTH], 1);
        @(posedge wr_clk);
        #1;
        s_valid = 1'b0;
        @(negedge wr_clk);
        chk("parity03_wr_en", fifo_wr_en, 1);
        chk("parity03_bit", fifo_data[WIDTH], 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_frontend.md
Name:
fifo_wr_frontend

Overview:
- Write-side ingress stage in the wr_clk domain, directly upstream of the asynchronous FIFO.
- Accepts a valid/ready word stream with packet delimiters and holds words in a 2-entry skid buffer.
- Drives the FIFO write port and honours its full flag.
- Optionally drops the rest of a packet when the FIFO stays full too long, and keeps saturating statistics counters.

Parameters:
- WIDTH, 8: data word width; matches the FIFO data width.
- STALL_LIMIT, 16: consecutive fifo_full cycles with a pending word before DROP is entered (drop_mode=1 only). Legal range 1..255.
- CNT_W, 16: width of each statistics counter.

Ports:
- wr_clk  input  1  write-domain clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  frontend can accept a word this cycle.
- s_data  input  WIDTH  upstream word.
- s_last  input  1  word is the last of its packet.
- drop_mode  input  1  1 enables the stall-timeout drop policy; sampled every cycle.
- fifo_full  input  1  FIFO full flag, already in the wr_clk domain.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_data  output  WIDTH (WIDTH+1 with WR_PARITY_EN)  FIFO write data.
- busy  output  1  state != IDLE or skid buffer not empty.
- words_written  output  CNT_W  count of words written to the FIFO.
- stall_cycles  output  CNT_W  count of cycles with a pending head word and fifo_full=1.
- pkts_written  output  CNT_W  count of words written with last=1.
- words_dropped  output  CNT_W  count of discarded words.

Behaviour:
- Reset values: s_ready=0, fifo_wr_en=0, fifo_data=0, busy=0, all counters 0, state=IDLE, both buffer entries invalid, stall timer 0.
- s_ready comes from a register. It goes to 1 on the first clock after reset deasserts.
- Handshake: a word is accepted when s_valid & s_ready at a rising edge. s_data and s_last are stored with the word, so both buffer entries hold {data, last}.
- Skid buffer: entry H (head) and entry S (skid).
  - An accepted word goes to H if H is empty or H is being written this cycle.
  - Otherwise it goes to S.
  - When H is written and S is valid, S moves to H.
  - s_ready is 0 when S is valid.
  - Word order is always preserved.
- fifo_wr_en = H valid & ~fifo_full & (state != DROP). This is the only combinational path from fifo_full.
- fifo_data = H.data.
- Latency: a word accepted at edge N can be written at edge N+1 at the earliest.
- With fifo_full=0 and s_valid held at 1, throughput is one word per cycle.
- State machine:
  - IDLE: H empty. A word accepted -> PASS.
  - PASS: H valid and fifo_full=0. If H is written and no word is left -> IDLE. If fifo_full=1 with H valid -> STALL.
  - STALL: stall timer increments each cycle with fifo_full=1 and resets when fifo_full=0. When fifo_full drops -> PASS.
  - STALL with drop_mode=1 and timer reaching STALL_LIMIT -> DROP. With drop_mode=0, STALL is held indefinitely.
  - DROP:
    - On entry, H and S are cleared; each valid entry adds 1 to words_dropped.
    - s_ready is held at 1; each accepted word is discarded and counted in words_dropped.
    - DROP exits to IDLE after a discarded word with last=1 (from the buffer or the input).
    - fifo_wr_en is 0 throughout DROP.
- Simultaneous events:
  - Accept and FIFO write in the same cycle keep the occupancy unchanged.
  - fifo_full rising in the same cycle as a write blocks that write, because fifo_wr_en is combinational.
- Counters saturate at all-ones and never wrap.
  - words_written increments on each fifo_wr_en.
  - pkts_written increments on fifo_wr_en & H.last.
  - stall_cycles increments each cycle H is valid & fifo_full & state != DROP.
- Reset mid-operation: buffer contents are lost, outputs return to their reset values immediately, and no partial-packet recovery is done.

Optional Feature:
- WR_PARITY_EN defined: fifo_data is WIDTH+1 bits; bit WIDTH = ^H.data (even parity over the data bits).
- WR_PARITY_EN undefined: fifo_data is WIDTH bits with no parity logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then stream 0x01..0x08, s_last on 0x08, fifo_full=0:
  - first fifo_wr_en 1 cycle after the first accept, then 8 consecutive writes;
  - words_written=8, pkts_written=1, busy=0 after.
- fifo_full=1 for 5 cycles mid-stream, drop_mode=0:
  - s_ready falls after 2 buffered words;
  - no write while full; stall_cycles=5;
  - order 0x01..0x08 preserved and no word lost.
- drop_mode=1, STALL_LIMIT=4, fifo_full held 1, 6-word packet:
  - DROP entered after 4 stall cycles; remaining words accepted with s_ready=1;
  - words_dropped=6, fifo_wr_en never asserts, then IDLE.
- Counter saturation at CNT_W=4 with 20 words: words_written=15 and holds.
- Assert reset while S is valid: all outputs are 0 immediately; after release s_ready=1 and the next packet passes cleanly.
- WR_PARITY_EN build, data 0x07: fifo_data[8]=1. Data 0x03: fifo_data[8]=0.
